// File: rtl/dw_fifoctl_lat_s1.sv
// Single-clock FIFO controller sequencing a two-port latch RAM as a circular buffer.
// Generates RAM pointers/strobes, occupancy flags and overflow/underflow error.
module dw_fifoctl_lat_s1 #(
   parameter int unsigned depth      = 8,
   parameter int unsigned addr_width = 3,
   parameter int unsigned ae_level   = 2,
   parameter int unsigned af_level   = 2,
   parameter int unsigned err_mode   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_req_n,
   input  logic                  pop_req_n,
   output logic                  ram_cs_n,
   output logic                  ram_wr_n,
   output logic [addr_width-1:0] wr_addr,
   output logic [addr_width-1:0] rd_addr,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  half_full,
   output logic                  almost_full,
   output logic                  full,
   output logic                  error,
   output logic [addr_width:0]   word_count
);

   localparam int unsigned AW = addr_width;
   localparam int unsigned CW = addr_width + 1;

   localparam logic [AW-1:0] LAST_ADDR = AW'(depth - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(depth);
   localparam logic [CW-1:0] AE_C      = CW'(ae_level);
   localparam logic [CW-1:0] HF_C      = CW'((depth + 1) / 2);
   localparam logic [CW-1:0] AF_C      = CW'(depth - af_level);

   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          empty_q, empty_d;
   logic          ae_q, ae_d;
   logic          hf_q, hf_d;
   logic          af_q, af_d;
   logic          full_q, full_d;
   logic          err_q, err_d;

   logic          push_ok_c;
   logic          pop_ok_c;
   logic          viol_c;

   // Request acceptance from registered state; rst_n gating keeps strobes quiet in reset.
   assign push_ok_c = rst_n & ~push_req_n & (~full_q | ~pop_req_n);
   assign pop_ok_c  = ~pop_req_n & ~empty_q;
   assign viol_c    = (~push_req_n & full_q & pop_req_n) | (~pop_req_n & empty_q);

   // Write strobe is low only in the low clock phase, so the latch closes before wr_addr moves.
   assign ram_wr_n = clk | ~push_ok_c;
   assign ram_cs_n = ~(push_ok_c | ~empty_q);

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push_ok_c) begin
         wr_d = (wr_q == LAST_ADDR) ? '0 : wr_q + AW'(1);
      end
      if (pop_ok_c) begin
         rd_d = (rd_q == LAST_ADDR) ? '0 : rd_q + AW'(1);
      end
      case ({push_ok_c, pop_ok_c})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Flags follow the next count so they line up with word_count every cycle.
   always_comb begin
      empty_d = (cnt_d == '0);
      ae_d    = (cnt_d <= AE_C);
      hf_d    = (cnt_d >= HF_C);
      af_d    = (cnt_d >= AF_C);
      full_d  = (cnt_d == DEPTH_C);
      err_d   = (err_mode == 0) ? (err_q | viol_c) : viol_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         empty_q <= 1'b1;
         ae_q    <= 1'b1;
         hf_q    <= 1'b0;
         af_q    <= 1'b0;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         empty_q <= empty_d;
         ae_q    <= ae_d;
         hf_q    <= hf_d;
         af_q    <= af_d;
         full_q  <= full_d;
         err_q   <= err_d;
      end
   end

   assign wr_addr      = wr_q;
   assign rd_addr      = rd_q;
   assign word_count   = cnt_q;
   assign empty        = empty_q;
   assign almost_empty = ae_q;
   assign half_full    = hf_q;
   assign almost_full  = af_q;
   assign full         = full_q;
   assign error        = err_q;

endmodule

// File: doc/dw_fifoctl_lat_s1.md
Name: dw_fifoctl_lat_s1

Overview:
- Single-clock synchronous FIFO controller that sequences a two-port latch-based RAM (separate read/write addresses, active-low chip select and write enable, asynchronous read) as a circular FIFO.
- Generates write/read addresses, RAM write strobe and chip select, occupancy-derived status flags and an overflow/underflow error.
- Sits between producer/consumer logic and the latch RAM instance. The RAM's data_in/data_out connect directly to the user data path, bypassing the controller.

Parameters:
- depth, 8, FIFO word count, 2..256.
- addr_width, 3, RAM address width, must equal ceil(log2(depth)).
- ae_level, 2, almost_empty asserts when count <= ae_level, 1..depth-1.
- af_level, 2, almost_full asserts when free slots <= af_level, 1..depth-1.
- err_mode, 0:
  - 0 = error is sticky until reset.
  - 1 = error reflects the previous cycle's violation only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- push_req_n  in  1  active-low push request.
- pop_req_n  in  1  active-low pop request.
- ram_cs_n  out  1  RAM chip select, active low.
- ram_wr_n  out  1  RAM write enable, active low, clock-phase gated.
- wr_addr  out  addr_width  RAM write address (tail pointer).
- rd_addr  out  addr_width  RAM read address (head pointer).
- empty  out  1  FIFO holds 0 words.
- almost_empty  out  1  count <= ae_level.
- half_full  out  1  count >= (depth+1)/2.
- almost_full  out  1  depth-count <= af_level.
- full  out  1  count == depth.
- error  out  1  overflow/underflow indication.
- word_count  out  addr_width+1  current occupancy, 0..depth.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_addr=0, rd_addr=0, word_count=0.
  - empty=1, almost_empty=1, half_full=0, almost_full=0, full=0, error=0.
  - ram_wr_n=1, ram_cs_n=1.
  - A reset mid-operation discards all contents. No write strobe may occur while rst_n is low.
- Accept rules, evaluated each cycle from the registered state:
  - push_ok = !push_req_n && (!full || !pop_req_n).
  - pop_ok = !pop_req_n && !empty.
  - Push on full with a simultaneous pop: both accepted, count unchanged.
  - Push and pop on empty: push accepted, pop rejected (underflow).
- RAM strobes:
  - ram_wr_n = clk | !push_ok. Low only in the low phase of the cycle in which the push is accepted, so the latch closes before wr_addr advances.
  - ram_cs_n = !(push_ok || !empty).
  - No registered latency on these strobes.
- Pointers:
  - On push_ok, wr_addr increments.
  - On pop_ok, rd_addr increments.
  - Both pointers wrap from depth-1 to 0, including when depth is not a power of two.
- Read data latency: data_out at rd_addr is valid combinationally (async read) whenever empty=0. Popped data is taken in the same cycle pop_req_n is asserted.
- Count: word_count += push_ok - pop_ok, registered. It never exceeds depth and never goes below 0.
- Flags:
  - All flags are registered and derived from the next value of word_count, so they are consistent with word_count every cycle.
  - Flags change one edge after the accepted request.
- Error:
  - Violation = (!push_req_n && full && pop_req_n) || (!pop_req_n && empty).
  - err_mode 0: error sets on the edge after a violation and holds until reset.
  - err_mode 1: error = registered violation of the previous cycle.
  - A rejected request never changes pointers, count or RAM contents.
- Idle (both requests deasserted): no state change, ram_wr_n stays high.

Test Plan (depth=8, ae_level=2, af_level=2):
1. Reset, then 8 consecutive pushes of 0x11..0x88:
   - ram_wr_n pulses low in the low phase of each of the 8 cycles.
   - wr_addr steps 0..7 then wraps to 0.
   - After the 8th edge: full=1, almost_full=1, word_count=8.
   - Flags over the sequence: almost_empty clears at count 3, half_full sets at count 4, almost_full sets at count 6.
2. From full, push alone:
   - No ram_wr_n pulse, wr_addr unchanged, word_count=8.
   - error=1 next edge and held (err_mode 0).
   - A following simultaneous push+pop: word_count stays 8, both pointers advance.
3. From empty, pop alone:
   - rd_addr unchanged, error=1.
   - With err_mode 1, error returns to 0 one cycle after the request is removed.
4. Empty, simultaneous push+pop of 0x5A:
   - Push accepted, pop rejected, word_count=1, empty=0, error asserted.
   - Next cycle, pop alone: rd_addr advances, RAM output read as 0x5A, empty=1.
5. Fill 5 words, pop 5, push 6 more (pointer wrap):
   - rd_addr/wr_addr wrap 7->0 correctly.
   - Popped data order matches push order; word_count=6 at the end.
6. Assert rst_n low mid-burst (count=4) asynchronously between edges:
   - All outputs take reset values immediately.
   - No ram_wr_n pulse occurs during reset.
   - The first push after release writes address 0.
